// File: rtl/dcm_clkgen_prog_responder.sv
// dcm_clkgen_prog_responder
//   Emulates the DCM_CLKGEN dynamic-reprogramming port. It accepts serial
//   LoadM/LoadD frames and a GO command on PROGEN/PROGDATA. It holds the
//   active M-1/D-1 values and emulates a relock period after each GO.
//
// Parameters
//   DEFAULT_M1   M-1 value loaded at reset
//   DEFAULT_D1   D-1 value loaded at reset
//   LOCK_CYCLES  relock duration in clk_i cycles (2..65535)
//
// Ports
//   clk_i       PROGCLK; all inputs are sampled on its rising edge
//   reset_i     synchronous active-high reset
//   progen_i    PROGEN program enable
//   progdata_i  PROGDATA serial command/data
//   progdone_o  PROGDONE, high when idle and reprogramming is complete
//   locked_o    emulated LOCKED
//   mult_m1_o   active M-1
//   div_m1_o    active D-1
//   err_o       sticky protocol error flag
//
// Build option
//   CLKGEN_PROG_ERRCHK_EN  enables the error flag, and rejects a GO with pending M-1 = 0.
module dcm_clkgen_prog_responder #(
    parameter logic [7:0]  DEFAULT_M1  = 8'd1,
    parameter logic [7:0]  DEFAULT_D1  = 8'd1,
    parameter int unsigned LOCK_CYCLES = 64
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       progen_i,
    input  logic       progdata_i,
    output logic       progdone_o,
    output logic       locked_o,
    output logic [7:0] mult_m1_o,
    output logic [7:0] div_m1_o,
    output logic       err_o
);

    typedef enum logic [2:0] {StIdle, StCmd, StShift, StGap, StRelock} state_e;

    state_e      state_q, state_d;
    logic        tgt_m_q, tgt_m_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  pend_m1_q, pend_m1_d;
    logic [7:0]  pend_d1_q, pend_d1_d;
    logic [7:0]  mult_q, mult_d;
    logic [7:0]  div_q, div_d;
    logic [15:0] cnt_q, cnt_d;
    // One-cycle event pulses; they delay the visible output change by one edge.
    logic        go_q, go_d;
    logic        exit_q, exit_d;
    logic        start_q, start_d;
    logic        locked_q, locked_d;
    logic        progdone_q, progdone_d;
    logic        err_set;

    always_comb begin
        state_d    = state_q;
        tgt_m_d    = tgt_m_q;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        pend_m1_d  = pend_m1_q;
        pend_d1_d  = pend_d1_q;
        cnt_d      = cnt_q;
        go_d       = 1'b0;
        exit_d     = 1'b0;
        start_d    = 1'b0;
        err_set    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (progen_i) begin
                    if (progdata_i) begin
                        state_d = StCmd;
                        start_d = 1'b1;
                    end else begin
`ifdef CLKGEN_PROG_ERRCHK_EN
                        if (pend_m1_q == 8'd0) begin
                            err_set = 1'b1;
                        end else begin
                            state_d = StRelock;
                            cnt_d   = 16'(LOCK_CYCLES - 1);
                            go_d    = 1'b1;
                        end
`else
                        state_d = StRelock;
                        cnt_d   = 16'(LOCK_CYCLES - 1);
                        go_d    = 1'b1;
`endif
                    end
                end
            end
            StCmd: begin
                if (progen_i) begin
                    tgt_m_d  = progdata_i;
                    bitcnt_d = 3'd0;
                    state_d  = StShift;
                end else begin
                    state_d = StIdle;
                    err_set = 1'b1;
                end
            end
            StShift: begin
                if (progen_i) begin
                    // LSB arrives first, so shift in from the top.
                    shreg_d  = {progdata_i, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = StGap;
                    end
                end else begin
                    state_d = StIdle;
                    err_set = 1'b1;
                end
            end
            StGap: begin
                if (!progen_i) begin
                    state_d = StIdle;
                    if (tgt_m_q) begin
                        pend_m1_d = shreg_q;
                    end else begin
                        pend_d1_d = shreg_q;
                    end
                end else begin
                    err_set = 1'b1;
                end
            end
            StRelock: begin
                if (progen_i) begin
                    err_set = 1'b1;
                end
                if (cnt_q == 16'd0) begin
                    state_d = StIdle;
                    exit_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mult_d     = mult_q;
        div_d      = div_q;
        locked_d   = locked_q;
        progdone_d = progdone_q;
        if (go_q) begin
            mult_d     = pend_m1_q;
            div_d      = pend_d1_q;
            locked_d   = 1'b0;
            progdone_d = 1'b0;
        end
        if (exit_q) begin
            locked_d   = 1'b1;
            progdone_d = 1'b1;
        end
        if (start_q) begin
            progdone_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            tgt_m_q    <= 1'b0;
            shreg_q    <= 8'd0;
            bitcnt_q   <= 3'd0;
            pend_m1_q  <= DEFAULT_M1;
            pend_d1_q  <= DEFAULT_D1;
            mult_q     <= DEFAULT_M1;
            div_q      <= DEFAULT_D1;
            cnt_q      <= 16'd0;
            go_q       <= 1'b0;
            exit_q     <= 1'b0;
            start_q    <= 1'b0;
            locked_q   <= 1'b1;
            progdone_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            tgt_m_q    <= tgt_m_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            pend_m1_q  <= pend_m1_d;
            pend_d1_q  <= pend_d1_d;
            mult_q     <= mult_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            go_q       <= go_d;
            exit_q     <= exit_d;
            start_q    <= start_d;
            locked_q   <= locked_d;
            progdone_q <= progdone_d;
        end
    end

`ifdef CLKGEN_PROG_ERRCHK_EN
    logic err_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | err_set;
        end
    end

    assign err_o = err_q;
`else
    logic unused_err_set;
    assign unused_err_set = err_set;
    assign err_o          = 1'b0;
`endif

    assign progdone_o = progdone_q;
    assign locked_o   = locked_q;
    assign mult_m1_o  = mult_q;
    assign div_m1_o   = div_q;

endmodule

// File: tb/tb_dcm_clkgen_prog_responder.sv
module tb_dcm_clkgen_prog_responder;

    localparam int LOCK = 64;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       progen_i;
    logic       progdata_i;
    logic       progdone_o;
    logic       locked_o;
    logic [7:0] mult_m1_o;
    logic [7:0] div_m1_o;
    logic       err_o;

    int checks = 0;
    int errors = 0;

`ifdef CLKGEN_PROG_ERRCHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    dcm_clkgen_prog_responder #(
        .DEFAULT_M1 (8'd1),
        .DEFAULT_D1 (8'd1),
        .LOCK_CYCLES(LOCK)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .progen_i  (progen_i),
        .progdata_i(progdata_i),
        .progdone_o(progdone_o),
        .locked_o  (locked_o),
        .mult_m1_o (mult_m1_o),
        .div_m1_o  (div_m1_o),
        .err_o     (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i    = 1'b1;
        progen_i   = 1'b0;
        progdata_i = 1'b0;
        tick();
        reset_i = 1'b0;
    endtask

    // Start bit, target bit, nbits value bits (LSB first), extra overlong cycles, then the gap.
    task automatic send_frame(input logic is_m, input logic [7:0] val, input int nbits,
                              input int extra);
        progen_i   = 1'b1;
        progdata_i = 1'b1;
        tick();
        progdata_i = is_m;
        tick();
        for (int i = 0; i < nbits; i++) begin
            progdata_i = val[i];
            tick();
        end
        for (int e = 0; e < extra; e++) begin
            progdata_i = ~progdata_i;
            tick();
        end
        progen_i   = 1'b0;
        progdata_i = 1'b0;
        tick();
    endtask

    task automatic send_go();
        progen_i   = 1'b1;
        progdata_i = 1'b0;
        tick();
        progen_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (mult_m1_o !== 8'd1) begin errors++;
            $display("FAIL reset_mult got %h exp 01", mult_m1_o); end
        checks++; if (div_m1_o !== 8'd1) begin errors++;
            $display("FAIL reset_div got %h exp 01", div_m1_o); end
        checks++; if (progdone_o !== 1'b1) begin errors++;
            $display("FAIL reset_progdone got %b exp 1", progdone_o); end
        checks++; if (locked_o !== 1'b1) begin errors++;
            $display("FAIL reset_locked got %b exp 1", locked_o); end
        checks++; if (err_o !== 1'b0) begin errors++;
            $display("FAIL reset_err got %b exp 0", err_o); end
    endtask

    task automatic test_load_go();
        // progdone falls one cycle after the start bit
        progen_i   = 1'b1;
        progdata_i = 1'b1;
        tick();
        checks++; if (progdone_o !== 1'b1) begin errors++;
            $display("FAIL progdone_at_start got %b exp 1", progdone_o); end
        progdata_i = 1'b1;
        tick();
        checks++; if (progdone_o !== 1'b0) begin errors++;
            $display("FAIL progdone_after_start got %b exp 0", progdone_o); end
        for (int i = 0; i < 8; i++) begin
            progdata_i = (8'h09 >> i) & 8'h01;
            tick();
        end
        progen_i   = 1'b0;
        progdata_i = 1'b0;
        tick();
        send_frame(1'b0, 8'h03, 8, 0);
        checks++; if (mult_m1_o !== 8'd1 || div_m1_o !== 8'd1) begin errors++;
            $display("FAIL active_before_go got %h/%h exp 01/01", mult_m1_o, div_m1_o); end
        send_go();  // edge N
        checks++; if (locked_o !== 1'b1) begin errors++;
            $display("FAIL locked_at_n got %b exp 1", locked_o); end
        tick();     // N+1
        checks++; if (mult_m1_o !== 8'h09 || div_m1_o !== 8'h03) begin errors++;
            $display("FAIL applied_n1 got %h/%h exp 09/03", mult_m1_o, div_m1_o); end
        checks++; if (locked_o !== 1'b0 || progdone_o !== 1'b0) begin errors++;
            $display("FAIL relock_n1 got lk=%b pd=%b exp 0/0", locked_o, progdone_o); end
        repeat (LOCK - 1) tick();  // N+64
        checks++; if (locked_o !== 1'b0 || progdone_o !== 1'b0) begin errors++;
            $display("FAIL relock_n64 got lk=%b pd=%b exp 0/0", locked_o, progdone_o); end
        tick();     // N+65
        checks++; if (locked_o !== 1'b1 || progdone_o !== 1'b1) begin errors++;
            $display("FAIL relock_n65 got lk=%b pd=%b exp 1/1", locked_o, progdone_o); end
    endtask

    task automatic test_abort();
        send_frame(1'b1, 8'h05, 4, 0);
        send_go();
        repeat (LOCK + 1) tick();
        checks++; if (mult_m1_o !== 8'h09 || div_m1_o !== 8'h03) begin errors++;
            $display("FAIL abort_keep got %h/%h exp 09/03", mult_m1_o, div_m1_o); end
        checks++; if (locked_o !== 1'b1) begin errors++;
            $display("FAIL abort_locked got %b exp 1", locked_o); end
        checks++; if (err_o !== ERR_EXP) begin errors++;
            $display("FAIL abort_err got %b exp %b", err_o, ERR_EXP); end
    endtask

    task automatic test_relock_ignore();
        do_reset();
        send_go();  // edge N
        repeat (9) tick();
        progen_i   = 1'b1;
        progdata_i = 1'b1;
        tick();     // N+10
        progen_i   = 1'b0;
        progdata_i = 1'b0;
        repeat (LOCK - 10) tick();  // N+64
        checks++; if (locked_o !== 1'b0) begin errors++;
            $display("FAIL ignore_n64 got %b exp 0", locked_o); end
        tick();     // N+65
        checks++; if (locked_o !== 1'b1 || progdone_o !== 1'b1) begin errors++;
            $display("FAIL ignore_n65 got lk=%b pd=%b exp 1/1", locked_o, progdone_o); end
        repeat (3) tick();
        checks++; if (progdone_o !== 1'b1) begin errors++;
            $display("FAIL ignore_idle got %b exp 1", progdone_o); end
        checks++; if (err_o !== ERR_EXP) begin errors++;
            $display("FAIL ignore_err got %b exp %b", err_o, ERR_EXP); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_frame(1'b1, 8'h20, 8, 0);
        send_go();
        repeat (30) tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        checks++; if (mult_m1_o !== 8'd1 || locked_o !== 1'b1 || progdone_o !== 1'b1)
        begin errors++;
            $display("FAIL reset_mid got m=%h lk=%b pd=%b exp 01/1/1",
                     mult_m1_o, locked_o, progdone_o); end
        send_go();
        repeat (LOCK + 1) tick();
        checks++; if (mult_m1_o !== 8'd1 || locked_o !== 1'b1) begin errors++;
            $display("FAIL reset_mid_pending got m=%h lk=%b exp 01/1", mult_m1_o, locked_o); end
    endtask

    task automatic test_overlong();
        do_reset();
        send_frame(1'b1, 8'h0A, 8, 3);
        checks++; if (mult_m1_o !== 8'd1 || progdone_o !== 1'b0) begin errors++;
            $display("FAIL overlong_pre got m=%h pd=%b exp 01/0", mult_m1_o, progdone_o); end
        send_go();
        repeat (LOCK + 1) tick();
        checks++; if (mult_m1_o !== 8'h0A) begin errors++;
            $display("FAIL overlong_val got %h exp 0a", mult_m1_o); end
        checks++; if (err_o !== ERR_EXP) begin errors++;
            $display("FAIL overlong_err got %b exp %b", err_o, ERR_EXP); end
    endtask

    task automatic test_order();
        do_reset();
        send_frame(1'b0, 8'h11, 8, 0);
        send_frame(1'b1, 8'h22, 8, 0);
        send_go();
        repeat (LOCK + 1) tick();
        checks++; if (mult_m1_o !== 8'h22 || div_m1_o !== 8'h11) begin errors++;
            $display("FAIL order got %h/%h exp 22/11", mult_m1_o, div_m1_o); end
        checks++; if (locked_o !== 1'b1 || progdone_o !== 1'b1) begin errors++;
            $display("FAIL order_done got lk=%b pd=%b exp 1/1", locked_o, progdone_o); end
    endtask

    task automatic test_m_zero();
        do_reset();
        send_frame(1'b1, 8'h00, 8, 0);
        send_go();
        tick();
        tick();
`ifdef CLKGEN_PROG_ERRCHK_EN
        checks++; if (locked_o !== 1'b1 || mult_m1_o !== 8'd1) begin errors++;
            $display("FAIL mzero_ignored got lk=%b m=%h exp 1/01", locked_o, mult_m1_o); end
        checks++; if (err_o !== 1'b1) begin errors++;
            $display("FAIL mzero_err got %b exp 1", err_o); end
`else
        checks++; if (locked_o !== 1'b0 || mult_m1_o !== 8'd0) begin errors++;
            $display("FAIL mzero_accept got lk=%b m=%h exp 0/00", locked_o, mult_m1_o); end
        checks++; if (err_o !== 1'b0) begin errors++;
            $display("FAIL mzero_err got %b exp 0", err_o); end
`endif
        repeat (LOCK) tick();
        checks++; if (locked_o !== 1'b1) begin errors++;
            $display("FAIL mzero_final_locked got %b exp 1", locked_o); end
    endtask

    initial begin
        reset_i    = 1'b1;
        progen_i   = 1'b0;
        progdata_i = 1'b0;
        test_reset();
        test_load_go();
        test_abort();
        test_relock_ignore();
        test_reset_mid();
        test_overlong();
        test_order();
        test_m_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
